// File: rtl/slow_div_param.sv
// -----------------------------------------------------------------------------
// slow_div_param
//
// Parametrised multi-cycle restoring divider. One quotient bit is retired per
// clock, so a normal division takes WIDTH cycles from the accepting edge to
// the valid edge. A zero divisor short-cuts to a one-cycle divide-by-zero
// result. Signed operation is selected per operation with signed_mode; the
// datapath itself always works on magnitudes and fixes up the signs at the end.
//
// Parameters:
//   WIDTH      operand / quotient / remainder width (2..32)
//   SIGNED_EN  1: signed_mode honoured, 0: unsigned-only build
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        request, sampled only while busy=0
//   signed_mode  1 = two's-complement operation, sampled with start
//   X            dividend, sampled with start
//   Y            divisor, sampled with start
//   busy         operation in progress (start ignored while high)
//   valid        one-cycle pulse, results updated this cycle
//   quot         quotient, held until the next completion
//   rem          remainder, held until the next completion
//   div_by_zero  Y was zero for the held result
//   ovf          signed MIN / -1 for the held result
// -----------------------------------------------------------------------------
module slow_div_param #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int unsigned        CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]    CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   MinVal  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDz
    } state_e;

    state_e           state_q, state_d;

    // Working registers
    logic [WIDTH-1:0] prem_q, prem_d;      // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
    logic [CntW-1:0]  cnt_q, cnt_d;        // remaining steps
    logic             qneg_q, qneg_d;      // negate quotient at the end
    logic             rneg_q, rneg_d;      // negate remainder at the end
    logic             ovf_pend_q, ovf_pend_d;

    // Result registers
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    // -------------------------------------------------------------------------
    // Operand preparation (used only on the accepting edge)
    // -------------------------------------------------------------------------
    logic             eff_signed;
    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic             is_min_m1;

    assign eff_signed = SIGNED_EN & signed_mode;
    assign x_neg      = eff_signed & X[WIDTH-1];
    assign y_neg      = eff_signed & Y[WIDTH-1];
    // -MIN wraps back to MIN, which read as unsigned is the correct magnitude.
    assign x_mag      = x_neg ? (~X + 1'b1) : X;
    assign y_mag      = y_neg ? (~Y + 1'b1) : Y;
    assign is_min_m1  = eff_signed && (X == MinVal) && (Y == {WIDTH{1'b1}});

    // -------------------------------------------------------------------------
    // One restoring step
    // -------------------------------------------------------------------------
    // The shifted remainder is WIDTH+1 bits wide. Its top bit set means it is
    // already >= any WIDTH-bit divisor, so the low WIDTH bits plus one borrow
    // bit are enough to decide the trial subtraction; when the step succeeds
    // the true difference is below the divisor and fits in WIDTH bits.
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] diff;
    logic             step_ok;
    logic [WIDTH-1:0] prem_step;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    assign shifted          = {prem_q, dvd_q[WIDTH-1]};
    assign {borrow, diff}   = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dvs_q};
    assign step_ok          = shifted[WIDTH] | ~borrow;
    assign prem_step        = step_ok ? diff : shifted[WIDTH-1:0];
    assign dvd_step         = {dvd_q[WIDTH-2:0], step_ok};
    assign quot_fin         = qneg_q ? (~dvd_step + 1'b1) : dvd_step;
    assign rem_fin          = rneg_q ? (~prem_step + 1'b1) : prem_step;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        prem_d     = prem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (Y == '0) begin
                        // Keep the raw dividend; it becomes the remainder.
                        dvd_d   = X;
                        state_d = StDz;
                    end else begin
                        prem_d     = '0;
                        dvd_d      = x_mag;
                        dvs_d      = y_mag;
                        cnt_d      = CntLast;
                        qneg_d     = x_neg ^ y_neg;
                        rneg_d     = x_neg;
                        ovf_pend_d = is_min_m1;
                        state_d    = StCalc;
                    end
                end
            end

            StCalc: begin
                prem_d = prem_step;
                dvd_d  = dvd_step;
                if (cnt_q == '0) begin
                    quot_d  = quot_fin;
                    rem_d   = rem_fin;
                    dbz_d   = 1'b0;
                    ovf_d   = ovf_pend_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StDz: begin
                quot_d  = '1;
                rem_d   = dvd_q;
                dbz_d   = 1'b1;
                ovf_d   = 1'b0;
                valid_d = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            prem_q     <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prem_q     <= prem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // -------------------------------------------------------------------------
    assign busy        = (state_q != StIdle);
    assign valid       = valid_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign ovf         = ovf_q;

`ifndef SYNTHESIS
    a_valid_not_busy: assert property (@(posedge clk) disable iff (!rst)
        valid |-> !busy);
    a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(div_by_zero && ovf));
    a_idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst)
        (state_q == StIdle) |-> (cnt_q == '0));
`endif

endmodule
